// File: rtl/search_mc_capture_sched_if.sv
// Requester, shared-path and result signals of the multicycle capture scheduler.
// master = requesters/path environment side, slave = scheduler side.
interface search_mc_capture_sched_if #(
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [3:0]        dp_in;
    logic              dp_out;
    logic [NREQ-1:0]   res_q;
    logic [NREQ-1:0]   res_valid;

    modport master (
        output req_valid, req_data, dp_out,
        input  req_ready, dp_in, res_q, res_valid
    );

    modport slave (
        input  req_valid, req_data, dp_out,
        output req_ready, dp_in, res_q, res_valid
    );
endinterface

// File: rtl/search_mc_capture_sched.sv
// Round-robin scheduler sharing one multicycle combinational path among NREQ requesters.
// Optional per-requester saturating grant counters when SCHED_STATS_EN is defined.
module search_mc_capture_sched #(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned MC_CYCLES = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    search_mc_capture_sched_if.slave  bus,
`ifdef SCHED_STATS_EN
    output logic [NREQ*CNT_W-1:0]     stat_grants,
`endif
    output logic                      busy
);
    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned MC_W  = 4;

    typedef enum logic {IDLE, WAIT} state_e;

    state_e            state_q, state_d;
    logic [MC_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [3:0]        dp_in_q, dp_in_d;
    logic [NREQ-1:0]   res_q_q, res_q_d;
    logic [NREQ-1:0]   res_vld_q, res_vld_d;

    logic              win_found_c;
    logic [IDX_W-1:0]  win_c;
    logic [NREQ-1:0]   req_ready_c;
    logic              accept_c;
    logic [3:0]        win_data_c;
    int unsigned       idx_c;

    // Round-robin winner search starting after the last grant.
    always_comb begin
        win_found_c = 1'b0;
        win_c       = '0;
        idx_c       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx_c = (32'(last_q) + k) % NREQ;
            if (!win_found_c && bus.req_valid[IDX_W'(idx_c)]) begin
                win_found_c = 1'b1;
                win_c       = IDX_W'(idx_c);
            end
        end
    end

    always_comb begin
        req_ready_c = '0;
        win_data_c  = '0;
        if (state_q == IDLE && rst_n && win_found_c) begin
            req_ready_c[win_c] = 1'b1;
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == win_c) begin
                win_data_c = bus.req_data[4*i +: 4];
            end
        end
        accept_c = |(req_ready_c & bus.req_valid);
    end

    // Next-state: launch on accept, count down, capture dp_out when cnt hits zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        dp_in_d   = dp_in_q;
        res_q_d   = res_q_q;
        res_vld_d = '0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    dp_in_d = win_data_c;
                    gnt_d   = win_c;
                    last_d  = win_c;
                    cnt_d   = MC_W'(MC_CYCLES - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - MC_W'(1);
                end else begin
                    res_q_d[gnt_q]   = bus.dp_out;
                    res_vld_d[gnt_q] = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt_q     <= '0;
            last_q    <= IDX_W'(NREQ - 1);
            dp_in_q   <= '0;
            res_q_q   <= '0;
            res_vld_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            dp_in_q   <= dp_in_d;
            res_q_q   <= res_q_d;
            res_vld_q <= res_vld_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.dp_in     = dp_in_q;
    assign bus.res_q     = res_q_q;
    assign bus.res_valid = res_vld_q;
    assign busy          = (state_q != IDLE);

`ifdef SCHED_STATS_EN
    logic [CNT_W-1:0] stat_q [NREQ];
    logic [CNT_W-1:0] stat_d [NREQ];

    // Saturating per-requester grant counters.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            stat_d[i] = stat_q[i];
            if (accept_c && win_c == IDX_W'(i) && stat_q[i] != '1) begin
                stat_d[i] = stat_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!rst_n) begin
                stat_q[i] <= '0;
            end else begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_grants[g*CNT_W +: CNT_W] = stat_q[g];
    end
`endif
endmodule

// File: tb/tb_search_mc_capture_sched.sv
// Directed self-checking bench for search_mc_capture_sched (NREQ=3, MC_CYCLES=3, CNT_W=8).
// The shared path is modelled as (in1&in2)&(in3|in4), or overridden by a bench-driven value.
module tb_search_mc_capture_sched;
    localparam int unsigned NREQ      = 3;
    localparam int unsigned MC_CYCLES = 3;
    localparam int unsigned CNT_W     = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic dp_mode;
    logic dp_force;
    int   total = 0;
    int   bad   = 0;
`ifdef SCHED_STATS_EN
    logic [NREQ*CNT_W-1:0] stat_grants;
`endif

    search_mc_capture_sched_if #(.NREQ(NREQ)) bus ();

    search_mc_capture_sched #(
        .NREQ(NREQ), .MC_CYCLES(MC_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
`ifdef SCHED_STATS_EN
        .stat_grants(stat_grants),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign bus.dp_out = dp_mode ? dp_force
                                : ((bus.dp_in[0] & bus.dp_in[1]) & (bus.dp_in[2] | bus.dp_in[3]));

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_data  = 12'hABC;
        step();
        step();
        #1;
        total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (bus.dp_in !== 4'h0) begin bad++; $display("FAIL reset_dp_in got=%h exp=0", bus.dp_in); end
        total++; if (bus.res_q !== 3'b000) begin bad++; $display("FAIL reset_res_q got=%b exp=000", bus.res_q); end
        total++; if (bus.res_valid !== 3'b000) begin bad++; $display("FAIL reset_res_valid got=%b exp=000", bus.res_valid); end
        bus.req_valid = 3'b000;
        rst_n         = 1'b1;
        step();
    endtask

    task automatic test_single();
        bus.req_valid = 3'b010;
        bus.req_data  = {4'b0000, 4'b0111, 4'b0000};
        #1;
        total++; if (bus.req_ready !== 3'b010) begin bad++; $display("FAIL single_ready got=%b exp=010", bus.req_ready); end
        step();
        bus.req_valid = 3'b000;
        #1;
        total++; if (bus.dp_in !== 4'b0111) begin bad++; $display("FAIL single_dp_in got=%b exp=0111", bus.dp_in); end
        for (int c = 0; c < 3; c++) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy c=%0d got=%b exp=1", c, busy); end
            total++; if (bus.res_valid !== 3'b000) begin bad++; $display("FAIL single_early_valid c=%0d got=%b exp=000", c, bus.res_valid); end
            step();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        total++; if (bus.res_q !== 3'b010) begin bad++; $display("FAIL single_res_q got=%b exp=010", bus.res_q); end
        total++; if (bus.res_valid !== 3'b010) begin bad++; $display("FAIL single_res_valid got=%b exp=010", bus.res_valid); end
        step();
        total++; if (bus.res_valid !== 3'b000) begin bad++; $display("FAIL single_valid_pulse got=%b exp=000", bus.res_valid); end
        total++; if (bus.dp_in !== 4'b0111) begin bad++; $display("FAIL single_dp_hold got=%b exp=0111", bus.dp_in); end
    endtask

    task automatic test_fairness();
        logic [3:0] dat [3];
        logic [2:0] exp_rdy;
        dat[0] = 4'b0111;
        dat[1] = 4'b0011;
        dat[2] = 4'b1011;
        do_reset();
        bus.req_data  = {dat[2], dat[1], dat[0]};
        bus.req_valid = 3'b111;
        for (int a = 0; a < 6; a++) begin
            exp_rdy = 3'b001 << (a % 3);
            #1;
            total++; if (bus.req_ready !== exp_rdy) begin bad++; $display("FAIL fair_ready a=%0d got=%b exp=%b", a, bus.req_ready, exp_rdy); end
            step();
            total++; if (bus.dp_in !== dat[a % 3]) begin bad++; $display("FAIL fair_dp_in a=%0d got=%b exp=%b", a, bus.dp_in, dat[a % 3]); end
            for (int w = 0; w < 2; w++) begin
                step();
                total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL fair_wait_ready a=%0d got=%b exp=000", a, bus.req_ready); end
            end
            step();
            total++; if (bus.res_valid !== exp_rdy) begin bad++; $display("FAIL fair_res_valid a=%0d got=%b exp=%b", a, bus.res_valid, exp_rdy); end
        end
        bus.req_valid = 3'b000;
        step();
        total++; if (bus.res_q !== 3'b101) begin bad++; $display("FAIL fair_res_q got=%b exp=101", bus.res_q); end
    endtask

    task automatic run_capture(input logic first_v, input logic last_v, input logic [2:0] exp_res);
        dp_mode       = 1'b1;
        dp_force      = first_v;
        bus.req_valid = 3'b001;
        #1;
        total++; if (bus.req_ready !== 3'b001) begin bad++; $display("FAIL capture_ready got=%b exp=001", bus.req_ready); end
        step();
        bus.req_valid = 3'b000;
        step();
        step();
        dp_force = last_v;
        step();
        total++; if (bus.res_q !== exp_res) begin bad++; $display("FAIL capture_res_q got=%b exp=%b", bus.res_q, exp_res); end
        total++; if (bus.res_valid !== 3'b001) begin bad++; $display("FAIL capture_res_valid got=%b exp=001", bus.res_valid); end
        dp_force = ~last_v;
        step();
        total++; if (bus.res_q !== exp_res) begin bad++; $display("FAIL capture_hold got=%b exp=%b", bus.res_q, exp_res); end
        dp_mode = 1'b0;
    endtask

    task automatic test_capture_window();
        run_capture(1'b1, 1'b0, 3'b100);
        run_capture(1'b0, 1'b1, 3'b101);
    endtask

    task automatic test_abort();
        bus.req_data  = {4'b0111, 4'b0111, 4'b0111};
        bus.req_valid = 3'b010;
        #1;
        total++; if (bus.req_ready !== 3'b010) begin bad++; $display("FAIL abort_ready got=%b exp=010", bus.req_ready); end
        step();
        bus.req_valid = 3'b000;
        step();
        rst_n = 1'b0;
        step();
        total++; if (bus.res_valid !== 3'b000) begin bad++; $display("FAIL abort_res_valid got=%b exp=000", bus.res_valid); end
        total++; if (bus.res_q !== 3'b000) begin bad++; $display("FAIL abort_res_q got=%b exp=000", bus.res_q); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (bus.dp_in !== 4'h0) begin bad++; $display("FAIL abort_dp_in got=%h exp=0", bus.dp_in); end
        rst_n = 1'b1;
        step();
        total++; if (bus.res_valid !== 3'b000) begin bad++; $display("FAIL abort_late_valid got=%b exp=000", bus.res_valid); end
        bus.req_valid = 3'b111;
        #1;
        total++; if (bus.req_ready !== 3'b001) begin bad++; $display("FAIL abort_next_grant got=%b exp=001", bus.req_ready); end
        step();
        bus.req_valid = 3'b000;
        step();
        step();
        step();
        total++; if (bus.res_valid !== 3'b001) begin bad++; $display("FAIL abort_after_valid got=%b exp=001", bus.res_valid); end
        total++; if (bus.res_q !== 3'b001) begin bad++; $display("FAIL abort_after_res_q got=%b exp=001", bus.res_q); end
    endtask

`ifdef SCHED_STATS_EN
    task automatic test_stats();
        do_reset();
        bus.req_valid = 3'b001;
        step();
        step();
        step();
        step();
        total++; if (stat_grants !== 24'h000001) begin bad++; $display("FAIL stats_one got=%h exp=000001", stat_grants); end
        for (int n = 1; n < 300; n++) begin
            step();
            step();
            step();
            step();
        end
        bus.req_valid = 3'b000;
        step();
        total++; if (stat_grants[7:0] !== 8'd255) begin bad++; $display("FAIL stats_sat got=%0d exp=255", stat_grants[7:0]); end
        total++; if (stat_grants[23:8] !== 16'h0000) begin bad++; $display("FAIL stats_others got=%h exp=0000", stat_grants[23:8]); end
    endtask
`endif

    initial begin
        dp_mode       = 1'b0;
        dp_force      = 1'b0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fairness();
        test_capture_window();
        test_abort();
`ifdef SCHED_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
